// File: rtl/sha256_transform_core.sv
// SHA-256 compression engine: 64/LOOP round stages, each reused LOOP times per block,
// followed by a registered add of the chaining state.
module sha256_transform_core #(
  parameter int unsigned LOOP = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         feedback,
  input  logic [5:0]   cnt,
  input  logic [255:0] rx_state,
  input  logic [511:0] rx_input,
  output logic [255:0] tx_hash
);

  localparam int unsigned NSTAGE = 64 / LOOP;

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  // One round on working variables; word 0 = a ... word 7 = h.
  function automatic logic [7:0][31:0] round_v(input logic [7:0][31:0] v,
                                               input logic [31:0] k,
                                               input logic [31:0] w0);
    logic [31:0] t1;
    logic [31:0] t2;
    t1 = v[7] + bsig1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + k + w0;
    t2 = bsig0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
    return {v[6:4], 32'(v[3] + t1), v[2:0], 32'(t1 + t2)};
  endfunction

  // Sliding message window: drop W[0], append the next schedule word.
  function automatic logic [15:0][31:0] round_w(input logic [15:0][31:0] w);
    return {32'(ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0]), w[15:1]};
  endfunction

  logic [7:0][31:0]  stage_v [NSTAGE];
  logic [15:0][31:0] stage_w [NSTAGE];
  logic [7:0][31:0]  src_v   [NSTAGE];
  logic [15:0][31:0] src_w   [NSTAGE];

  // Stage source: own registers when folding, otherwise the predecessor.
  always_comb begin
    src_v[0] = feedback ? stage_v[0] : rx_state;
    src_w[0] = feedback ? stage_w[0] : rx_input;
    for (int s = 1; s < int'(NSTAGE); s++) begin
      src_v[s] = feedback ? stage_v[s] : stage_v[s-1];
      src_w[s] = feedback ? stage_w[s] : stage_w[s-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < int'(NSTAGE); s++) begin
        stage_v[s] <= '0;
        stage_w[s] <= '0;
      end
      tx_hash <= '0;
    end else begin
      for (int s = 0; s < int'(NSTAGE); s++) begin
        stage_v[s] <= round_v(src_v[s], K_TAB[6'(LOOP * 32'(s)) + cnt], src_w[s][0]);
        stage_w[s] <= round_w(src_w[s]);
      end
      // Chaining-state feed-forward; rx_state is held stable by the driver.
      for (int j = 0; j < 8; j++) begin
        tx_hash[32*j +: 32] <= rx_state[32*j +: 32] + stage_v[NSTAGE-1][j];
      end
    end
  end

endmodule

// File: tb/tb_sha256_transform_core.sv
// Bench for sha256_transform_core: streaming, folded, chained double hash and async reset.
module tb_sha256_transform_core;

  localparam logic [255:0] IV = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                                 32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef struct {
    logic [255:0] st;
    logic [511:0] blk;
    logic [255:0] exp;
    logic         known;
    logic [31:0]  w0;
    logic [31:0]  w7;
  } vec_t;

  logic         clk;
  logic         reset_n;
  logic [255:0] st_a, st_f;
  logic [511:0] in_a, in_b, in_f;
  logic [255:0] tx_a, tx_b, tx_f;
  logic         fb_f;
  logic [5:0]   cnt_f;

  int checks   = 0;
  int failures = 0;
  vec_t tv [16];

  sha256_transform_core #(.LOOP(1)) u_a (
    .clk(clk), .reset_n(reset_n), .feedback(1'b0), .cnt(6'd0),
    .rx_state(st_a), .rx_input(in_a), .tx_hash(tx_a)
  );

  // Second hash of the chain: IV plus {padding, first digest}.
  assign in_b = {32'h00000100, 192'h0, 32'h80000000, tx_a};

  sha256_transform_core #(.LOOP(1)) u_b (
    .clk(clk), .reset_n(reset_n), .feedback(1'b0), .cnt(6'd0),
    .rx_state(IV), .rx_input(in_b), .tx_hash(tx_b)
  );

  sha256_transform_core #(.LOOP(4)) u_f (
    .clk(clk), .reset_n(reset_n), .feedback(fb_f), .cnt(cnt_f),
    .rx_state(st_f), .rx_input(in_f), .tx_hash(tx_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference SHA-256 compression straight from the FIPS 180-4 formulation.
  function automatic logic [255:0] compress(input logic [255:0] st, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    logic [255:0] r;
    for (int i = 0; i < 16; i++) w[i] = blk[32*i +: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = s1 + w[i-7] + s0 + w[i-16];
    end
    a = st[31:0];    b = st[63:32];   c = st[95:64];   d = st[127:96];
    e = st[159:128]; f = st[191:160]; g = st[223:192]; h = st[255:224];
    for (int i = 0; i < 64; i++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + KT[i] + w[i];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    r = {h, g, f, e, d, c, b, a};
    for (int j = 0; j < 8; j++) r[32*j +: 32] = r[32*j +: 32] + st[32*j +: 32];
    return r;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int j = 0; j < 16; j++) r[32*j +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int j = 0; j < 8; j++) r[32*j +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [255:0] st, input logic [511:0] blk,
                         input logic known, input logic [31:0] w0, input logic [31:0] w7);
    tv[i].st    = st;
    tv[i].blk   = blk;
    tv[i].exp   = compress(st, blk);
    tv[i].known = known;
    tv[i].w0    = w0;
    tv[i].w7    = w7;
  endtask

  // Drive one vector per cycle into u_a; each result appears 65 edges later.
  task automatic run_stream(input int n, input string tag);
    int idx;
    for (int k = 0; k < n + 65; k++) begin
      @(negedge clk);
      if (k >= 65) begin
        idx = k - 65;
        chk(tag, tx_a, tv[idx].exp);
        if (tv[idx].known) begin
          chk({tag, "_w0"}, {224'h0, tx_a[31:0]}, {224'h0, tv[idx].w0});
          chk({tag, "_w7"}, {224'h0, tx_a[255:224]}, {224'h0, tv[idx].w7});
        end
      end
      if (k < n) begin
        st_a = tv[k].st;
        in_a = tv[k].blk;
      end
    end
  endtask

  logic [511:0] abc_blk, empty_blk, hb1, hb2;
  logic [511:0] fblk [3];
  logic [255:0] fexp [3];
  logic [255:0] s_rand, mid, h1, h2;

  initial begin
    reset_n = 1'b0;
    st_a = IV; in_a = '0;
    st_f = IV; in_f = '0; fb_f = 1'b0; cnt_f = 6'd0;

    abc_blk = '0;   abc_blk[31:0] = 32'h61626380; abc_blk[511:480] = 32'h00000018;
    empty_blk = '0; empty_blk[31:0] = 32'h80000000;

    // Run 1: known digests alternating every cycle, then random blocks, IV chaining state.
    set_vec(0, IV, abc_blk,   1'b1, 32'hba7816bf, 32'hf20015ad);
    set_vec(1, IV, empty_blk, 1'b1, 32'he3b0c442, 32'h7852b855);
    set_vec(2, IV, abc_blk,   1'b1, 32'hba7816bf, 32'hf20015ad);
    set_vec(3, IV, empty_blk, 1'b1, 32'he3b0c442, 32'h7852b855);
    for (int i = 4; i < 12; i++) set_vec(i, IV, rand512(), 1'b0, 32'h0, 32'h0);

    repeat (2) @(negedge clk);
    chk("reset_a", tx_a, '0);
    chk("reset_b", tx_b, '0);
    chk("reset_f", tx_f, '0);
    reset_n = 1'b1;

    run_stream(12, "stream_iv");

    // Run 2: random but stable chaining state.
    s_rand = rand256();
    for (int i = 0; i < 8; i++) set_vec(i, s_rand, rand512(), 1'b0, 32'h0, 32'h0);
    run_stream(8, "stream_rs");

    // Folded LOOP=4: load on cnt=0, then three feedback cycles with junk on rx_input.
    fblk[0] = abc_blk; fblk[1] = rand512(); fblk[2] = rand512();
    for (int i = 0; i < 3; i++) fexp[i] = compress(IV, fblk[i]);
    for (int c = 0; c < 74; c++) begin
      @(negedge clk);
      if (c >= 65 && (c - 65) % 4 == 0) begin
        chk("fold", tx_f, fexp[(c - 65) / 4]);
        if (c == 65) chk("fold_abc_w0", {224'h0, tx_f[31:0]}, {224'h0, 32'hba7816bf});
      end
      fb_f  = (c % 4) != 0;
      cnt_f = 6'(c % 4);
      if (c % 4 == 0 && c / 4 < 3) in_f = fblk[c / 4];
      else in_f = rand512();
    end
    fb_f = 1'b0; cnt_f = 6'd0;

    // Double hash of the 80-byte genesis header (midstate + tail, then IV + digest).
    hb1 = '0;
    hb1[31:0] = 32'h01000000;
    hb1[32*9 +: 32] = 32'h3ba3edfd; hb1[32*10 +: 32] = 32'h7a7b12b2;
    hb1[32*11 +: 32] = 32'h7ac72c3e; hb1[32*12 +: 32] = 32'h67768f61;
    hb1[32*13 +: 32] = 32'h7fc81bc3; hb1[32*14 +: 32] = 32'h888a5132;
    hb1[32*15 +: 32] = 32'h3a9fb8aa;
    hb2 = '0;
    hb2[31:0] = 32'h4b1e5e4a; hb2[63:32] = 32'h29ab5f49; hb2[95:64] = 32'hffff001d;
    hb2[127:96] = 32'h1dac2b7c; hb2[159:128] = 32'h80000000; hb2[511:480] = 32'h00000280;
    mid = compress(IV, hb1);
    h1  = compress(mid, hb2);
    h2  = compress(IV, {32'h00000100, 192'h0, 32'h80000000, h1});
    @(negedge clk);
    st_a = mid; in_a = hb2;
    repeat (131) @(negedge clk);
    chk("chain_first", tx_a, h1);
    chk("chain_second", tx_b, h2);
    chk("golden_h7", {224'h0, tx_b[255:224]}, 256'h0);
    chk("golden_h0", {224'h0, tx_b[31:0]}, {224'h0, 32'h6fe28c0a});

    // Async reset mid-stream, then a fresh stream afterwards.
    st_a = IV;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_a = rand512();
    end
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async_a", tx_a, '0);
    chk("rst_async_b", tx_b, '0);
    chk("rst_async_f", tx_f, '0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_hold_a", tx_a, '0);
    reset_n = 1'b1;

    s_rand = rand256();
    set_vec(0, s_rand, abc_blk, 1'b0, 32'h0, 32'h0);
    for (int i = 1; i < 6; i++) set_vec(i, s_rand, rand512(), 1'b0, 32'h0, 32'h0);
    run_stream(6, "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sha256_transform_core.md
# sha256_transform_core

Pipelined SHA-256 compression engine for the mining datapath. It applies the 64 SHA-256 rounds to a 512-bit message block starting from a supplied 256-bit chaining state, and adds that chaining state to the result. The top level instantiates two of these back to back: midstate plus header tail, then a fixed IV plus the first digest. Parameter `LOOP` trades area for throughput: `64/LOOP` physical round stages, each reused `LOOP` times per block.

## Interface
- `LOOP`, default 1: rounds folded per physical stage; legal values 1, 2, 4, 8, 16, 32. The stage count is `NSTAGE = 64/LOOP`.
- `clk` input 1: sole clock; all registers update on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `feedback` input 1: 0 = each stage loads from its predecessor; 1 = each stage reloads its own registers. Must be 0 when `LOOP`=1.
- `cnt` input 6: round offset within a stage, range 0..LOOP-1. Must be 0 when `LOOP`=1.
- `rx_state` input 256: chaining state. Word j is `[32j+31:32j]`; word 0 = A (H0), word 7 = H (H7).
- `rx_input` input 512: message block. Word j is `[32j+31:32j]`, holding W[j]; W0 is in `[31:0]`.
- `tx_hash` output 256: registered digest, same word order as `rx_state`.

## Operation
- Stage s (0..NSTAGE-1) holds a register set: working variables a..h (8×32 bits) and a 16-word message window W[0..15].
- Stage input source:
  - If `feedback`=1: the stage's own registers.
  - Otherwise: stage s-1's registers. For stage 0, a..h come from `rx_state` words 0..7 and the window from `rx_input` words 0..15.
- Each clock, every stage performs one standard SHA-256 round on its source values, using constant K[LOOP*s + cnt] and window word W[0].
- Window update for that round:
  - W'[i] = W[i+1] for i = 0..14.
  - W'[15] = σ1(W[14]) + W[9] + σ0(W[1]) + W[0].
  - All additions are mod 2^32.
- Σ0, Σ1, σ0, σ1, Ch, Maj and the K table follow FIPS 180-4.
- Output register: each clock, `tx_hash` word j ← `rx_state` word j + final-stage register word j (mod 2^32, per word, no carry between words).
- Chaining-state stability: `rx_state` must be held constant for the full block latency, because it is sampled again at the output add. The top level guarantees this; the block does not pipeline a copy.
- Reset (`reset_n`=0): all stage registers and `tx_hash` clear to 0 immediately, regardless of `clk`. Release takes effect at the next rising edge.

## Timing
- `LOOP`=1:
  - Fully pipelined; accepts a new block every cycle.
  - A block presented before edge n is visible on `tx_hash` after edge n+64, i.e. 65 edges, one per stage plus the output register.
- `LOOP`>1:
  - The driver asserts `feedback`=0 with `cnt`=0 on the load edge.
  - It then asserts `feedback`=1 with `cnt`=1..LOOP-1 for the next LOOP-1 edges, and repeats this pattern.
  - New blocks are accepted only on load edges, giving throughput of 1 block per LOOP cycles.
  - Latency remains 65 edges.
  - `tx_hash` is valid only in the cycle following a load edge. At other times it holds partially advanced values, and consumers must qualify it with their delayed `feedback`.
- No valid/ready handshake exists; validity is implied by schedule position.
- Outputs are undefined (but deterministic) for the first 65 edges after reset release: they are computed from the reset zeros.

## Test plan
- **LOOP=1, "abc"**
  - Stimulus: `rx_state` = IV (word 0 = 6a09e667 … word 7 = 5be0cd19); `rx_input` W0 = 61626380, W15 = 00000018, all other words 0.
  - Required: after 65 edges, `tx_hash` word 0 = ba7816bf and word 7 = f20015ad.
- **LOOP=1, empty message**
  - Stimulus: IV; W0 = 80000000, all other words 0.
  - Required: `tx_hash` word 0 = e3b0c442, word 7 = 7852b855.
- **LOOP=1 streaming**
  - Stimulus: alternate the "abc" and empty blocks on consecutive cycles.
  - Required: outputs alternate correctly every cycle, starting at edge 65.
- **LOOP=4 folded**
  - Stimulus: "abc" with the feedback/cnt schedule (0/0, 1/1, 1/2, 1/3, repeat).
  - Required: ba7816bf… on `tx_hash` in the cycle after the load edge, 65 edges from input.
- **Chained double hash**
  - Stimulus: two instances, with the second fed IV and {padding, first digest}.
  - Required: matches software SHA-256d for an 80-byte header, including golden nonce detection of the upper word being 00000000.
- **Async reset mid-stream**
  - Stimulus: pull `reset_n` low between edges.
  - Required: `tx_hash` reads 0 immediately; after release, new blocks emerge correctly after 65 edges.
